// File: rtl/prga.sv
// ARC4 pseudo-random generation stage: walks ct[], evolves S, writes pt[] = keystream ^ ct.
// Single-port memories with one-cycle read latency; all outputs are registered.
module prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, LAT_LEN, WR_LEN,
    RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, RD_PAD, LAT_PAD, WR_PT
  } state_t;

  state_t     state_q;
  logic       rdy_q;
  logic [7:0] s_addr_q, s_wrdata_q, ct_addr_q, pt_addr_q, pt_wrdata_q;
  logic       s_wren_q, pt_wren_q;
  logic [7:0] i_q, j_q, k_q, len_q, si_q, sj_q, ctk_q;

  logic [7:0] i_d, j_d, k_d, pad_addr_d;
  logic       unused_pt;

  assign unused_pt = ^pt_rddata;

  always_comb begin
    i_d        = i_q + 8'd1;
    j_d        = j_q + s_rddata;
    k_d        = k_q + 8'd1;
    pad_addr_d = si_q + sj_q;
  end

  // Addresses are loaded on the transition into each RD_* state so that the
  // read data is valid in the following LAT_* state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      len_q       <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      ctk_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            rdy_q     <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            ct_addr_q <= '0;
            state_q   <= RD_LEN;
          end
        end
        RD_LEN: state_q <= LAT_LEN;
        LAT_LEN: begin
          len_q       <= ct_rddata;
          pt_addr_q   <= '0;
          pt_wrdata_q <= ct_rddata;
          pt_wren_q   <= 1'b1;
          state_q     <= WR_LEN;
        end
        WR_LEN: begin
          pt_wren_q <= 1'b0;
          if (len_q == '0) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            k_q      <= 8'd1;
            i_q      <= i_d;
            s_addr_q <= i_d;
            state_q  <= RD_I;
          end
        end
        RD_I: state_q <= LAT_I;
        LAT_I: begin
          si_q      <= s_rddata;
          j_q       <= j_d;
          s_addr_q  <= j_d;
          ct_addr_q <= k_q;
          state_q   <= RD_J;
        end
        RD_J: state_q <= LAT_J;
        LAT_J: begin
          sj_q       <= s_rddata;
          ctk_q      <= ct_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= s_rddata;
          s_wren_q   <= 1'b1;
          state_q    <= WR_I;
        end
        WR_I: begin
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          state_q    <= WR_J;
        end
        WR_J: begin
          s_wren_q <= 1'b0;
          s_addr_q <= pad_addr_d;
          state_q  <= RD_PAD;
        end
        RD_PAD: state_q <= LAT_PAD;
        LAT_PAD: begin
          pt_addr_q   <= k_q;
          pt_wrdata_q <= s_rddata ^ ctk_q;
          pt_wren_q   <= 1'b1;
          state_q     <= WR_PT;
        end
        WR_PT: begin
          pt_wren_q <= 1'b0;
          if (k_q == len_q) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            k_q      <= k_d;
            i_q      <= i_d;
            s_addr_q <= i_d;
            state_q  <= RD_I;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

endmodule
